// File: rtl/data_path.sv
// Operational datapath: result register y, step counter s, and write-tracking
// status (update pulse, update count, sticky s wrap flag).
module data_path #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic          y_en,
  input  logic          y_store_x,
  input  logic [1:0]    y_select_next,
  input  logic          s_en,
  input  logic          s_zero,
  input  logic          s_add,
  input  logic [1:0]    s_step,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          s_is_zero,
  output logic          y_upd,
  output logic [CW-1:0] upd_cnt,
  output logic          s_wrap
);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] s_q, s_d;
  logic          y_upd_q;
  logic [CW-1:0] upd_cnt_q, upd_cnt_d;
  logic          s_wrap_q, s_wrap_d;

  logic [SW:0]   s_base_ext;
  logic [SW:0]   s_step_ext;
  logic [SW:0]   s_res_ext;

  // One extra bit catches both carry-out and borrow: bit SW is set exactly
  // when the unbounded result falls outside 0..2^SW-1.
  always_comb begin
    s_base_ext = s_zero ? '0 : {1'b0, s_q};
    s_step_ext = (SW+1)'(s_step);
    s_res_ext  = s_add ? (s_base_ext + s_step_ext) : (s_base_ext - s_step_ext);
  end

  always_comb begin
    s_d      = s_q;
    s_wrap_d = s_wrap_q;
    if (s_en) begin
      s_d = s_res_ext[SW-1:0];
      if (s_res_ext[SW])
        s_wrap_d = 1'b1;
      else if (s_zero)
        s_wrap_d = 1'b0;
    end
  end

  always_comb begin
    y_d       = y_q;
    upd_cnt_d = upd_cnt_q;
    if (y_en) begin
      upd_cnt_d = upd_cnt_q + 1'b1;
      if (y_store_x) begin
        y_d = x;
      end else begin
        unique case (y_select_next)
          2'd0: y_d = y_q;
          2'd1: y_d = y_q + 1'b1;
          2'd2: y_d = {y_q[W-2:0], y_q[W-1]};
          2'd3: y_d = y_q + W'(s_q);
          default: y_d = y_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q       <= '0;
      s_q       <= '0;
      y_upd_q   <= 1'b0;
      upd_cnt_q <= '0;
      s_wrap_q  <= 1'b0;
    end else begin
      y_q       <= y_d;
      s_q       <= s_d;
      y_upd_q   <= y_en;
      upd_cnt_q <= upd_cnt_d;
      s_wrap_q  <= s_wrap_d;
    end
  end

  assign y         = y_q;
  assign s         = s_q;
  assign s_is_zero = (s_q == '0);
  assign y_upd     = y_upd_q;
  assign upd_cnt   = upd_cnt_q;
  assign s_wrap    = s_wrap_q;

endmodule
